// File: rtl/sorting_pkg.sv
// ---------------------------------------------------------------------------
// sorting_pkg
// Shared definitions for the in-place RAM sorter.
//   N_DEF / L_DEF / M_DEF : default word width, address width, element count
//   state_e               : sequencer states used by sorting_top
// ---------------------------------------------------------------------------
package sorting_pkg;

  localparam int N_DEF = 8;  // data word width (unsigned)
  localparam int L_DEF = 4;  // address width, RAM depth 2**L
  localparam int M_DEF = 8;  // elements sorted, addresses 0..M-1

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    CMP,
    WR_J,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/sort_ram.sv
// ---------------------------------------------------------------------------
// sort_ram
// 2**L x N single-port RAM: asynchronous read, synchronous write, no reset.
// The caller multiplexes host and sequencer onto the single port.
//   clk     : clock
//   we_i    : write enable, write happens on the rising edge
//   addr_i  : shared read/write address
//   wdata_i : write data
//   rdata_o : combinational read data at addr_i
// ---------------------------------------------------------------------------
module sort_ram
  import sorting_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int L = L_DEF
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [L-1:0] addr_i,
  input  logic [N-1:0] wdata_i,
  output logic [N-1:0] rdata_o
);

  logic [N-1:0] mem_q [2**L];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/sorting_top.sv
// ---------------------------------------------------------------------------
// sorting_top
// In-place ascending exchange sort of RAM addresses 0..M-1.
// The host loads words while idle, pulses start, waits for done and reads
// the sorted words back through the same address port.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset (RAM contents are kept)
//   Rd      : read enable; DataOut is 0 when low
//   WrInit  : host write enable, honoured only while idle
//   RAddr   : host address for reads and writes
//   DataIn  : host write data
//   start   : begin a sort, accepted only while idle
//   DataOut : mem[RAddr] when Rd=1 (contents meaningful only while idle)
//   done    : high from sort completion until the next accepted start
// ---------------------------------------------------------------------------
module sorting_top
  import sorting_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int L = L_DEF,
  parameter int M = M_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         Rd,
  input  logic         WrInit,
  input  logic [L-1:0] RAddr,
  input  logic [N-1:0] DataIn,
  input  logic         start,
  output logic [N-1:0] DataOut,
  output logic         done
);

  // Loop bounds: the inner index stops at M-1, the outer at M-2, so the
  // L-bit counters never wrap.
  localparam logic [L-1:0] J_LAST = L'(M - 1);
  localparam logic [L-1:0] I_LAST = L'(M - 2);

  state_e       state_q;
  logic [L-1:0] i_q;
  logic [L-1:0] j_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         done_q;

  logic         ram_we;
  logic [L-1:0] ram_addr;
  logic [N-1:0] ram_wdata;
  logic [N-1:0] ram_rdata;
  logic         swap;

  // Strict unsigned less-than: equal keys are left in place.
  assign swap = (b_q < a_q);

  // Single RAM port: host owns it in IDLE, the sequencer everywhere else.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = RAddr;
    ram_wdata = DataIn;
    unique case (state_q)
      IDLE: begin
        ram_we = WrInit;
      end
      LOAD_A: begin
        ram_addr = i_q;
      end
      LOAD_B: begin
        ram_addr = j_q;
      end
      CMP: begin
        ram_addr  = i_q;
        ram_we    = swap;
        ram_wdata = b_q;
      end
      WR_J: begin
        // b_q was swapped with a_q in CMP, so it now holds the old mem[i].
        ram_addr  = j_q;
        ram_we    = 1'b1;
        ram_wdata = b_q;
      end
      default: begin
        ram_addr = RAddr;
      end
    endcase
  end

  sort_ram #(
    .N(N),
    .L(L)
  ) u_ram (
    .clk    (clk),
    .we_i   (ram_we),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          // A coincident host write lands on this same edge, so the first
          // LOAD_A already sees it.
          if (start) begin
            state_q <= LOAD_A;
            i_q     <= '0;
            j_q     <= '0;
            done_q  <= 1'b0;
          end
        end
        LOAD_A: begin
          a_q     <= ram_rdata;
          j_q     <= i_q + 1'b1;
          state_q <= LOAD_B;
        end
        LOAD_B: begin
          b_q     <= ram_rdata;
          state_q <= CMP;
        end
        CMP: begin
          if (swap) begin
            // mem[i] <= b happens through the RAM port this cycle; keep the
            // displaced value in b_q for the WR_J write to mem[j].
            a_q     <= b_q;
            b_q     <= a_q;
            state_q <= WR_J;
          end else begin
            state_q <= NEXT;
          end
        end
        WR_J: begin
          state_q <= NEXT;
        end
        NEXT: begin
          if (j_q < J_LAST) begin
            j_q     <= j_q + 1'b1;
            state_q <= LOAD_B;
          end else if (i_q < I_LAST) begin
            i_q     <= i_q + 1'b1;
            state_q <= LOAD_A;
          end else begin
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign done    = done_q;
  assign DataOut = Rd ? ram_rdata : '0;

endmodule

// File: tb/tb_sorting_top.sv
// ---------------------------------------------------------------------------
// tb_sorting_top
// Directed bench for sorting_top with default parameters (N=8, L=4, M=8).
// Expected sorted data and exact sort latencies (92 + swap count) are worked
// out by hand for each input vector.
// ---------------------------------------------------------------------------
module tb_sorting_top;

  logic       clk;
  logic       rst;
  logic       Rd;
  logic       WrInit;
  logic [3:0] RAddr;
  logic [7:0] DataIn;
  logic       start;
  logic [7:0] DataOut;
  logic       done;

  int vectors;
  int miscompares;

  sorting_top #(
    .N(8),
    .L(4),
    .M(8)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .Rd     (Rd),
    .WrInit (WrInit),
    .RAddr  (RAddr),
    .DataIn (DataIn),
    .start  (start),
    .DataOut(DataOut),
    .done   (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- stimulus helpers (no checking inside) ----------------
  task automatic write_word(input logic [3:0] ad, input logic [7:0] d);
    @(negedge clk);
    WrInit = 1'b1;
    RAddr  = ad;
    DataIn = d;
    @(negedge clk);
    WrInit = 1'b0;
  endtask

  task automatic read_word(input logic [3:0] ad, output logic [7:0] d);
    @(negedge clk);
    Rd    = 1'b1;
    RAddr = ad;
    #1 d  = DataOut;
    Rd    = 1'b0;
  endtask

  task automatic load8(input logic [7:0] v [8]);
    for (int k = 0; k < 8; k++) begin
      write_word(4'(k), v[k]);
    end
  endtask

  // Pulses start for one cycle and counts rising edges after the start edge
  // until done is seen high; bounded at 200 cycles.
  task automatic run_sort(output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
  endtask

  // ------------------------------- tests ---------------------------------
  task automatic test_reset;
    rst    = 1'b0;
    Rd     = 1'b0;
    WrInit = 1'b0;
    RAddr  = 4'd5;
    DataIn = 8'd0;
    start  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_done: got %b want 0", done);
    end
    vectors++;
    if (DataOut !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_dataout_rd0: got %0d want 0", DataOut);
    end
    rst = 1'b1;
    $display("test_reset: done=%b DataOut=%0d", done, DataOut);
  endtask

  task automatic test_load_readback;
    logic [7:0] v [8];
    logic [7:0] d;
    v = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
    load8(v);
    for (int k = 0; k < 8; k++) begin
      read_word(4'(k), d);
      vectors++;
      if (d !== v[k]) begin
        miscompares++;
        $display("FAIL readback[%0d]: got %0d want %0d", k, d, v[k]);
      end
    end
    // Rd low must force zero even with non-zero RAM content addressed.
    @(negedge clk);
    RAddr = 4'd5;
    #1;
    vectors++;
    if (DataOut !== 8'd0) begin
      miscompares++;
      $display("FAIL rd_low_zero: got %0d want 0", DataOut);
    end
    $display("test_load_readback: 8 words loaded and read");
  endtask

  task automatic test_sort_mixed;
    logic [7:0] e [8];
    logic [7:0] d;
    int cyc;
    e = '{8'd12, 8'd23, 8'd34, 8'd45, 8'd56, 8'd67, 8'd78, 8'd89};
    run_sort(cyc);
    vectors++;
    if (done !== 1'b1 || cyc > 120) begin
      miscompares++;
      $display("FAIL mixed_done_bound: done=%b after %0d cycles, want 1 within 120", done, cyc);
    end
    // 11 swaps for this input: 92 + 11.
    vectors++;
    if (cyc != 103) begin
      miscompares++;
      $display("FAIL mixed_latency: got %0d want 103", cyc);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(4'(k), d);
      vectors++;
      if (d !== e[k]) begin
        miscompares++;
        $display("FAIL mixed_result[%0d]: got %0d want %0d", k, d, e[k]);
      end
    end
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL mixed_done_held: got %b want 1", done);
    end
    $display("test_sort_mixed: latency=%0d", cyc);
  endtask

  task automatic test_sorted_latency;
    logic [7:0] v [8];
    logic [7:0] d;
    int cyc;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load8(v);
    run_sort(cyc);
    vectors++;
    if (cyc != 92) begin
      miscompares++;
      $display("FAIL sorted_latency: got %0d want 92", cyc);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(4'(k), d);
      vectors++;
      if (d !== v[k]) begin
        miscompares++;
        $display("FAIL sorted_result[%0d]: got %0d want %0d", k, d, v[k]);
      end
    end
    $display("test_sorted_latency: latency=%0d", cyc);
  endtask

  task automatic test_reverse_dups;
    logic [7:0] v [8];
    logic [7:0] e [8];
    logic [7:0] d;
    int cyc;
    // Fully reversed: every pair swaps, 28 swaps -> 120 cycles.
    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    e = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load8(v);
    run_sort(cyc);
    vectors++;
    if (cyc != 120) begin
      miscompares++;
      $display("FAIL reverse_latency: got %0d want 120", cyc);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(4'(k), d);
      vectors++;
      if (d !== e[k]) begin
        miscompares++;
        $display("FAIL reverse_result[%0d]: got %0d want %0d", k, d, e[k]);
      end
    end
    $display("test_reverse: latency=%0d", cyc);
    // Duplicates: 8 swaps with strict compare; any swap of equal keys would
    // lengthen the run.
    v = '{8'd5, 8'd5, 8'd3, 8'd3, 8'd7, 8'd7, 8'd1, 8'd1};
    e = '{8'd1, 8'd1, 8'd3, 8'd3, 8'd5, 8'd5, 8'd7, 8'd7};
    load8(v);
    run_sort(cyc);
    vectors++;
    if (cyc != 100) begin
      miscompares++;
      $display("FAIL dups_latency: got %0d want 100", cyc);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(4'(k), d);
      vectors++;
      if (d !== e[k]) begin
        miscompares++;
        $display("FAIL dups_result[%0d]: got %0d want %0d", k, d, e[k]);
      end
    end
    $display("test_dups: latency=%0d", cyc);
  endtask

  task automatic test_ignored_start;
    logic [7:0] v [8];
    logic [7:0] d;
    int cyc;
    v = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
    load8(v);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    repeat (10) begin
      @(posedge clk);
      #1 cyc++;
    end
    // Mid-sort start and host write must both be ignored.
    start  = 1'b1;
    WrInit = 1'b1;
    RAddr  = 4'd3;
    DataIn = 8'd99;
    @(posedge clk);
    #1 cyc++;
    start  = 1'b0;
    WrInit = 1'b0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1 cyc++;
    end
    vectors++;
    if (cyc != 92) begin
      miscompares++;
      $display("FAIL ignored_start_latency: got %0d want 92", cyc);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(4'(k), d);
      vectors++;
      if (d !== v[k]) begin
        miscompares++;
        $display("FAIL ignored_write[%0d]: got %0d want %0d", k, d, v[k]);
      end
    end
    $display("test_ignored_start: latency=%0d", cyc);
  endtask

  task automatic test_midsort_reset;
    logic [7:0] v [8];
    logic [7:0] e [8];
    logic [7:0] d;
    int cyc;
    // done is high from the previous sort; async reset must drop it
    // without waiting for a clock edge.
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_done: got %b want 1", done);
    end
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset_done: got %b want 0", done);
    end
    @(negedge clk);
    rst = 1'b1;
    // Start a sort, then reset part way through.
    v = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    load8(v);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (done !== 1'b0) begin
      miscompares++;
      $display("FAIL midsort_reset_done: got %b want 0", done);
    end
    @(negedge clk);
    rst = 1'b1;
    // Back in IDLE: a host write must be accepted.
    write_word(4'd15, 8'd42);
    read_word(4'd15, d);
    vectors++;
    if (d !== 8'd42) begin
      miscompares++;
      $display("FAIL post_reset_write: got %0d want 42", d);
    end
    // Fresh sort from a full reload.
    v = '{8'd45, 8'd12, 8'd78, 8'd34, 8'd56, 8'd89, 8'd23, 8'd67};
    e = '{8'd12, 8'd23, 8'd34, 8'd45, 8'd56, 8'd67, 8'd78, 8'd89};
    load8(v);
    run_sort(cyc);
    vectors++;
    if (cyc != 103) begin
      miscompares++;
      $display("FAIL resort_latency: got %0d want 103", cyc);
    end
    for (int k = 0; k < 8; k++) begin
      read_word(4'(k), d);
      vectors++;
      if (d !== e[k]) begin
        miscompares++;
        $display("FAIL resort_result[%0d]: got %0d want %0d", k, d, e[k]);
      end
    end
    // Address 15 lies outside the sorted range and must be untouched.
    read_word(4'd15, d);
    vectors++;
    if (d !== 8'd42) begin
      miscompares++;
      $display("FAIL outside_range: got %0d want 42", d);
    end
    $display("test_midsort_reset: resort latency=%0d", cyc);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_load_readback();
    test_sort_mixed();
    test_sorted_latency();
    test_reverse_dups();
    test_ignored_start();
    test_midsort_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
